// File: rtl/writeback_unit_if.sv
// Writeback bus: ALU result, long-latency result handshake, issue/decode
// hazard query and the register file write port.
interface writeback_unit_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
);
  logic                  alu_we_i;
  logic [ADDR_WIDTH-1:0] alu_rd_i;
  logic [DATA_WIDTH-1:0] alu_data_i;
  logic                  lsu_valid_i;
  logic                  lsu_ready_o;
  logic [ADDR_WIDTH-1:0] lsu_rd_i;
  logic [DATA_WIDTH-1:0] lsu_data_i;
  logic                  issue_valid_i;
  logic [ADDR_WIDTH-1:0] issue_rd_i;
  logic [ADDR_WIDTH-1:0] dec_rs1_i;
  logic [ADDR_WIDTH-1:0] dec_rs2_i;
  logic [ADDR_WIDTH-1:0] dec_rd_i;
  logic                  dec_rd_we_i;
  logic                  stall_o;
  logic                  we_o;
  logic [ADDR_WIDTH-1:0] wr_addr_o;
  logic [DATA_WIDTH-1:0] wr_data_o;

  // Pipeline side driving results and decode queries
  modport master (
    output alu_we_i, alu_rd_i, alu_data_i,
    output lsu_valid_i, lsu_rd_i, lsu_data_i,
    output issue_valid_i, issue_rd_i,
    output dec_rs1_i, dec_rs2_i, dec_rd_i, dec_rd_we_i,
    input  lsu_ready_o, stall_o, we_o, wr_addr_o, wr_data_o
  );

  // Writeback unit side
  modport slave (
    input  alu_we_i, alu_rd_i, alu_data_i,
    input  lsu_valid_i, lsu_rd_i, lsu_data_i,
    input  issue_valid_i, issue_rd_i,
    input  dec_rs1_i, dec_rs2_i, dec_rd_i, dec_rd_we_i,
    output lsu_ready_o, stall_o, we_o, wr_addr_o, wr_data_o
  );
endinterface

// File: rtl/writeback_unit.sv
// Writeback unit: ALU results write through with priority, long-latency
// results queue in a small FIFO and drain on free cycles. A busy scoreboard
// stalls decode on RAW/WAW hazards against outstanding long-latency ops.
// Optional performance counters are enabled with `define WB_PERF_EN.
module writeback_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned REG_COUNT  = 32,
  parameter int unsigned BUF_DEPTH  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  writeback_unit_if.slave  bus
`ifdef WB_PERF_EN
  ,
  output logic [15:0]      perf_defer_o,
  output logic [15:0]      perf_stall_o
`endif
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

  wb_entry_t             mem_q [BUF_DEPTH];
  wb_entry_t             mem_d [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [REG_COUNT-1:0]  busy_q, busy_d;

  logic      alu_fire_c;
  logic      ready_c;
  logic      push_c;
  logic      drain_c;
  logic      stall_c;
  logic      issue_fire_c;
  wb_entry_t head_c;

  // Handshake, drain and hazard decisions from registered state
  always_comb begin
    alu_fire_c   = bus.alu_we_i && (bus.alu_rd_i != '0);
    ready_c      = (count_q != CNT_FULL);
    push_c       = bus.lsu_valid_i && ready_c;
    drain_c      = !alu_fire_c && (count_q != '0);
    head_c       = mem_q[rd_ptr_q];
    stall_c      = busy_q[bus.dec_rs1_i] || busy_q[bus.dec_rs2_i] ||
                   (bus.dec_rd_we_i && busy_q[bus.dec_rd_i]);
    issue_fire_c = bus.issue_valid_i && !stall_c && (bus.issue_rd_i != '0);
  end

  assign bus.lsu_ready_o = ready_c;
  assign bus.stall_o     = stall_c;

  // Register file write port: ALU first, else FIFO head, quiet in reset
  always_comb begin
    bus.we_o      = 1'b0;
    bus.wr_addr_o = '0;
    bus.wr_data_o = '0;
    if (rst_n) begin
      if (alu_fire_c) begin
        bus.we_o      = 1'b1;
        bus.wr_addr_o = bus.alu_rd_i;
        bus.wr_data_o = bus.alu_data_i;
      end else if (drain_c && (head_c.rd != '0)) begin
        bus.we_o      = 1'b1;
        bus.wr_addr_o = head_c.rd;
        bus.wr_data_o = head_c.data;
      end
    end
  end

  // Next FIFO and scoreboard state; a set on the same register beats a clear
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    busy_d   = busy_q;
    if (push_c) begin
      mem_d[wr_ptr_q] = '{rd: bus.lsu_rd_i, data: bus.lsu_data_i};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (drain_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (head_c.rd != '0) begin
        busy_d[head_c.rd] = 1'b0;
      end
    end
    if (issue_fire_c) begin
      busy_d[bus.issue_rd_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
    count_d   = count_q + CNT_W'(push_c) - CNT_W'(drain_c);
  end

  // FIFO and scoreboard registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(BUF_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
    end
  end

`ifdef WB_PERF_EN
  logic [15:0] perf_defer_q, perf_defer_d;
  logic [15:0] perf_stall_q, perf_stall_d;

  // Saturating counts of deferred drains and decode stall cycles
  always_comb begin
    perf_defer_d = perf_defer_q;
    perf_stall_d = perf_stall_q;
    if (alu_fire_c && (count_q != '0) && (perf_defer_q != 16'hFFFF)) begin
      perf_defer_d = perf_defer_q + 16'd1;
    end
    if (stall_c && (perf_stall_q != 16'hFFFF)) begin
      perf_stall_d = perf_stall_q + 16'd1;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_defer_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_defer_q <= perf_defer_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_defer_o = perf_defer_q;
  assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit with a reference FIFO/scoreboard model.
module tb_writeback_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  writeback_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

`ifdef WB_PERF_EN
  logic [15:0] perf_defer;
  logic [15:0] perf_stall;
`endif

  writeback_unit #(
    .DATA_WIDTH(32), .ADDR_WIDTH(5), .REG_COUNT(32), .BUF_DEPTH(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef WB_PERF_EN
    ,
    .perf_defer_o (perf_defer),
    .perf_stall_o (perf_stall)
`endif
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        exp_q[$];
  logic [31:0] mbusy;
  int          n_vec = 0;
  int          n_mis = 0;
  bit          p;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.alu_we_i = 1'b0;  bus.alu_rd_i = '0;  bus.alu_data_i = '0;
    bus.lsu_valid_i = 1'b0; bus.lsu_rd_i = '0; bus.lsu_data_i = '0;
    bus.issue_valid_i = 1'b0; bus.issue_rd_i = '0;
    bus.dec_rs1_i = '0; bus.dec_rs2_i = '0; bus.dec_rd_i = '0; bus.dec_rd_we_i = 1'b0;
  endtask

  // One cycle: check outputs mid-cycle against the model, then advance it
  task automatic step(input string tag, output bit pushed);
    logic        e_fire, e_ready, e_stall, e_we, dr;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    ent_t        h;
    @(negedge clk);
    e_fire  = bus.alu_we_i && (bus.alu_rd_i != 5'd0);
    e_ready = (exp_q.size() != 2);
    e_stall = mbusy[bus.dec_rs1_i] | mbusy[bus.dec_rs2_i] |
              (bus.dec_rd_we_i & mbusy[bus.dec_rd_i]);
    dr = 1'b0; e_we = 1'b0; e_addr = '0; e_data = '0; h = '0;
    if (e_fire) begin
      e_we = 1'b1; e_addr = bus.alu_rd_i; e_data = bus.alu_data_i;
    end else if (exp_q.size() != 0) begin
      h = exp_q[0];
      dr = 1'b1;
      if (h.rd != 5'd0) begin
        e_we = 1'b1; e_addr = h.rd; e_data = h.data;
      end
    end
    chk({tag, "/we"}, bus.we_o, e_we);
    if (e_we || !dr) begin
      chk({tag, "/addr"}, bus.wr_addr_o, e_addr);
      chk({tag, "/data"}, bus.wr_data_o, e_data);
    end
    chk({tag, "/ready"}, bus.lsu_ready_o, e_ready);
    chk({tag, "/stall"}, bus.stall_o, e_stall);
    if (dr) begin
      void'(exp_q.pop_front());
      if (h.rd != 5'd0) mbusy[h.rd] = 1'b0;
    end
    pushed = bus.lsu_valid_i && e_ready;
    if (pushed) exp_q.push_back('{rd: bus.lsu_rd_i, data: bus.lsu_data_i});
    if (bus.issue_valid_i && !e_stall && (bus.issue_rd_i != 5'd0))
      mbusy[bus.issue_rd_i] = 1'b1;
    mbusy[0] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    mbusy = '0;
    idle();
    // Reset with a live ALU request: outputs stay quiet
    rst_n = 1'b0;
    bus.alu_we_i = 1'b1; bus.alu_rd_i = 5'd5; bus.alu_data_i = 32'h55;
    repeat (2) @(posedge clk);
    #2;
    chk("rst/we", bus.we_o, 1'b0);
    chk("rst/addr", bus.wr_addr_o, 5'd0);
    chk("rst/data", bus.wr_data_o, 32'd0);
    chk("rst/stall", bus.stall_o, 1'b0);
    chk("rst/ready", bus.lsu_ready_o, 1'b1);
`ifdef WB_PERF_EN
    chk("rst/perf_defer", perf_defer, 16'd0);
    chk("rst/perf_stall", perf_stall, 16'd0);
`endif
    rst_n = 1'b1;
    step("rel_alu5", p);

    // Priority: ALU writes while {7,0x11} waits in the FIFO
    idle(); bus.issue_valid_i = 1'b1; bus.issue_rd_i = 5'd7;
    step("pri_issue7", p);
    idle(); bus.alu_we_i = 1'b1; bus.alu_rd_i = 5'd2; bus.alu_data_i = 32'h2222;
    bus.lsu_valid_i = 1'b1; bus.lsu_rd_i = 5'd7; bus.lsu_data_i = 32'h11;
    bus.dec_rs1_i = 5'd7;
    step("pri_push7", p);
    chk("pri_push_accepted", p, 1'b1);
    bus.lsu_valid_i = 1'b0; bus.alu_rd_i = 5'd3; bus.alu_data_i = 32'hA5A5A5A5;
    step("pri_alu3", p);
    bus.alu_we_i = 1'b0;
    step("pri_drain7", p);
    chk("pri_busy7_clear", bus.stall_o, 1'b0);
    step("pri_idle", p);

    // Full: two pushes fill the buffer, the third is held until a drain
    idle(); bus.alu_we_i = 1'b1; bus.alu_rd_i = 5'd10; bus.alu_data_i = 32'hA0;
    bus.lsu_valid_i = 1'b1; bus.lsu_rd_i = 5'd1; bus.lsu_data_i = 32'h101;
    step("full_push1", p);
    bus.lsu_rd_i = 5'd2; bus.lsu_data_i = 32'h102; bus.alu_data_i = 32'hA1;
    step("full_push2", p);
    bus.lsu_rd_i = 5'd3; bus.lsu_data_i = 32'h103; bus.alu_data_i = 32'hA2;
    chk("full_ready_low", bus.lsu_ready_o, 1'b0);
    step("full_hold", p);
    chk("full_held", p, 1'b0);
    bus.alu_we_i = 1'b0;
    p = 1'b0;
    for (int k = 0; k < 4 && !p; k++) step("full_drain", p);
    chk("full_push3_accepted", p, 1'b1);
    bus.lsu_valid_i = 1'b0;
    step("full_drain_tail", p);
    step("full_empty", p);
    chk("full_empty_we", bus.we_o, 1'b0);

    // Scoreboard: RAW stall, ignored issue, release one cycle after drain
    idle(); bus.issue_valid_i = 1'b1; bus.issue_rd_i = 5'd9;
    step("sb_issue9", p);
    bus.issue_rd_i = 5'd12; bus.dec_rs2_i = 5'd9;
    step("sb_stalled_issue12", p);
    chk("sb_stall_raw", bus.stall_o, 1'b1);
    bus.issue_valid_i = 1'b0; bus.dec_rs2_i = 5'd0; bus.dec_rs1_i = 5'd12;
    step("sb_no_busy12", p);
    bus.dec_rs1_i = 5'd0; bus.dec_rs2_i = 5'd9;
    bus.lsu_valid_i = 1'b1; bus.lsu_rd_i = 5'd9; bus.lsu_data_i = 32'h99;
    step("sb_push9", p);
    bus.lsu_valid_i = 1'b0;
    step("sb_drain9", p);
    chk("sb_release_next", bus.stall_o, 1'b0);
    step("sb_after", p);
    // WAW: destination match stalls only when rd is written
    idle(); bus.issue_valid_i = 1'b1; bus.issue_rd_i = 5'd15;
    step("waw_issue15", p);
    idle(); bus.dec_rd_i = 5'd15; bus.dec_rd_we_i = 1'b1;
    step("waw_stall", p);
    bus.dec_rd_we_i = 1'b0;
    step("waw_no_we", p);
    bus.lsu_valid_i = 1'b1; bus.lsu_rd_i = 5'd15; bus.lsu_data_i = 32'h1515;
    step("waw_push15", p);
    bus.lsu_valid_i = 1'b0;
    step("waw_drain15", p);

    // x0: popped without a write; issue to x0 never stalls
    idle(); bus.lsu_valid_i = 1'b1; bus.lsu_rd_i = 5'd0; bus.lsu_data_i = 32'hFFFFFFFF;
    step("x0_push", p);
    bus.lsu_valid_i = 1'b0;
    step("x0_pop", p);
    bus.issue_valid_i = 1'b1; bus.issue_rd_i = 5'd0;
    step("x0_issue", p);
    idle(); bus.dec_rd_we_i = 1'b1;
    step("x0_dec", p);
    chk("x0_no_stall", bus.stall_o, 1'b0);

    // Async reset with two buffered entries and busy[4]
    idle(); bus.alu_we_i = 1'b1; bus.alu_rd_i = 5'd11; bus.alu_data_i = 32'hB0;
    bus.issue_valid_i = 1'b1; bus.issue_rd_i = 5'd4;
    bus.lsu_valid_i = 1'b1; bus.lsu_rd_i = 5'd13; bus.lsu_data_i = 32'h13;
    step("ar_push13", p);
    bus.issue_valid_i = 1'b0; bus.lsu_rd_i = 5'd14; bus.lsu_data_i = 32'h14;
    bus.dec_rs1_i = 5'd4;
    step("ar_push14", p);
    bus.lsu_valid_i = 1'b0;
    chk("ar_full", bus.lsu_ready_o, 1'b0);
    chk("ar_busy4", bus.stall_o, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar/we", bus.we_o, 1'b0);
    chk("ar/ready", bus.lsu_ready_o, 1'b1);
    chk("ar/stall", bus.stall_o, 1'b0);
    exp_q.delete();
    mbusy = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.alu_we_i = 1'b0;
    for (int k = 0; k < 3; k++) step("ar_quiet", p);
`ifdef WB_PERF_EN
    chk("ar/perf_defer", perf_defer, 16'd0);
    chk("ar/perf_stall", perf_stall, 16'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
